// File: rtl/array_mult_arb.sv
// Round-robin arbiter sharing one array_mult among NREQ requesters.
// A tag pipe tracks the owner of each in-flight product and steers the result strobe.
module array_mult_arb #(
    parameter int N        = 3,
    parameter int NREQ     = 2,
    parameter int MULT_LAT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*N*45-1:0]          req_dataa,
    input  logic [NREQ*N*45-1:0]          req_datab,
    input  logic                          halt,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [N*45-1:0]               rsp_result,
    output logic                          mult_en,
    output logic [N*45-1:0]               mult_dataa,
    output logic [N*45-1:0]               mult_datab,
    input  logic [N*45-1:0]               mult_result,
    output logic [$clog2(MULT_LAT+2)-1:0] inflight,
    output logic                          idle
);

    localparam int VW   = N * 45;
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(MULT_LAT + 2);
    localparam int LAST = MULT_LAT;
    localparam logic [CW-1:0] INFL_MAX = CW'(MULT_LAT + 1);

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        if (id == IDW'(NREQ - 1)) begin
            next_id = '0;
        end else begin
            next_id = id + IDW'(1);
        end
    endfunction

    logic [IDW-1:0]  prio_r;
    logic [LAST:0]   tag_vld_r;
    logic [IDW-1:0]  tag_id_r [LAST+1];
    logic [CW-1:0]   inflight_r;

    logic [NREQ-1:0] hi_s;
    logic            hi_any_s;
    logic            any_s;
    logic [IDW-1:0]  pick_s;
    logic [NREQ-1:0] grant_s;
    logic            accept_s;
    logic [IDW-1:0]  sel_s;
    logic            rsp_any_s;

    // Round-robin pick: lowest valid index at or above prio, else lowest valid overall.
    always_comb begin
        hi_s     = req_valid & ~((NREQ'(1) << prio_r) - NREQ'(1));
        hi_any_s = |hi_s;
        any_s    = |req_valid;
        pick_s   = prio_r;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pick_s = (hi_any_s ? hi_s[k] : req_valid[k]) ? IDW'(k) : pick_s;
        end
        grant_s = '0;
        if (any_s && !halt && !reset) begin
            grant_s[pick_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign accept_s   = |grant_s;
    assign sel_s      = accept_s ? pick_s : prio_r;
    assign req_ready  = grant_s;
    assign mult_dataa = req_dataa[int'(sel_s) * VW +: VW];
    assign mult_datab = req_datab[int'(sel_s) * VW +: VW];

    // Multiplier stays enabled while any token is still inside mult_45; rounding stage runs free.
    assign mult_en    = accept_s | (|tag_vld_r[LAST-1:0]);
    assign rsp_any_s  = tag_vld_r[LAST];
    assign rsp_result = mult_result;
    assign inflight   = inflight_r;
    assign idle       = (inflight_r == '0) && (req_valid == '0);

    // Decode the owner of the token leaving the tag pipe into a one-hot strobe.
    always_comb begin
        rsp_valid = '0;
        if (rsp_any_s) begin
            rsp_valid[tag_id_r[LAST]] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    // Tag pipe, priority pointer and in-flight counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_vld_r  <= '0;
            prio_r     <= '0;
            inflight_r <= '0;
            for (int s = 0; s <= LAST; s++) begin
                tag_id_r[s] <= '0;
            end
        end else begin
            tag_vld_r   <= {tag_vld_r[LAST-1:0], accept_s};
            tag_id_r[0] <= pick_s;
            for (int s = 1; s <= LAST; s++) begin
                tag_id_r[s] <= tag_id_r[s-1];
            end
            if (accept_s) begin
                prio_r <= next_id(pick_s);
            end else begin
                prio_r <= prio_r;
            end
            case ({accept_s, rsp_any_s})
                2'b10: begin
                    if (inflight_r != INFL_MAX) begin
                        inflight_r <= inflight_r + CW'(1);
                    end else begin
                        inflight_r <= inflight_r;
                    end
                end
                2'b01: begin
                    if (inflight_r != '0) begin
                        inflight_r <= inflight_r - CW'(1);
                    end else begin
                        inflight_r <= inflight_r;
                    end
                end
                default: inflight_r <= inflight_r;
            endcase
        end
    end

endmodule
